// File: rtl/usrt_rx_ctrl.sv
// usrt_rx_ctrl: USRT receive controller.
// Deserialises 11-bit frames from the bit-clocked RX line and hands parity
// frames to an external checker with a one-cycle strobe. Accepted bytes are
// buffered in a show-ahead FIFO behind a valid/ready handshake.
// Frame, parity-timeout and overrun errors are reported as one-cycle pulses.

module usrt_rx_ctrl #(
    parameter int DEPTH    = 4,
    parameter int CHK_WAIT = 2
) (
    input  logic        i_Pclk,
    input  logic        i_Rst_n,
    input  logic        i_Enable,
    input  logic        i_Rx,
    input  logic [1:0]  i_Parity,
    output logic        o_ChkEnable,
    output logic [1:0]  o_ChkParity,
    output logic [10:0] o_ChkData,
    input  logic        i_ChkEnable,
    input  logic [7:0]  i_ChkData,
    output logic [7:0]  o_Data,
    output logic        o_Valid,
    input  logic        i_Ready,
    output logic        o_FrameErr,
    output logic        o_ParityErr,
    output logic        o_Overrun,
    output logic        o_Busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = (CHK_WAIT > 1) ? $clog2(CHK_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(CHK_WAIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
    typedef enum logic {C_IDLE, C_WAIT} chk_state_t;

    rx_state_t     rx_state, rx_next;
    logic [3:0]    bit_cnt;
    logic [9:0]    shift_reg;
    logic [1:0]    mode_q;
    logic          start_bit, shift_bit, frame_done;
    logic          frame_ready;

    chk_state_t    chk_state, chk_next;
    logic [WW-1:0] wait_cnt;
    logic          wait_last;
    logic          chk_start, push_direct, push_chk, timeout, push;
    logic [7:0]    push_data;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, pop, accept, overrun_now;

    // Receive FSM state register.
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) rx_state <= RX_IDLE;
        else          rx_state <= rx_next;
    end

    // Receive FSM next state: start bit opens a frame, bit 10 or a dropped enable closes it.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (i_Enable && !i_Rx) rx_next = RX_SHIFT;
            RX_SHIFT: if (!i_Enable || bit_cnt == 4'd10) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Receive FSM outputs: per-cycle control strobes for the shifter and handoff.
    always_comb begin
        start_bit  = 1'b0;
        shift_bit  = 1'b0;
        frame_done = 1'b0;
        case (rx_state)
            RX_IDLE:  start_bit = i_Enable & ~i_Rx;
            RX_SHIFT: begin
                shift_bit  = i_Enable & (bit_cnt != 4'd10);
                frame_done = i_Enable & (bit_cnt == 4'd10);
            end
            default: ;
        endcase
    end

    // Shift bits 0..9 in LSB first so bit0 lands in shift_reg[0]; mode 11 is folded to none.
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            mode_q    <= '0;
        end else if (start_bit) begin
            shift_reg <= {i_Rx, shift_reg[9:1]};
            bit_cnt   <= 4'd1;
            mode_q    <= (i_Parity == 2'b11) ? 2'b00 : i_Parity;
        end else if (shift_bit) begin
            shift_reg <= {i_Rx, shift_reg[9:1]};
            bit_cnt   <= bit_cnt + 4'd1;
        end
    end

    // Handoff register: freezes the completed frame so the shifter can start the next one.
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            frame_ready <= 1'b0;
            o_ChkData   <= '0;
            o_ChkParity <= '0;
        end else begin
            frame_ready <= frame_done;
            if (frame_done) begin
                o_ChkData   <= {i_Rx, shift_reg};
                o_ChkParity <= mode_q;
            end
        end
    end

    // Check stage state register.
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) chk_state <= C_IDLE;
        else          chk_state <= chk_next;
    end

    assign wait_last = (wait_cnt == WAIT_LAST);

    // Check stage next state: wait for the checker until it answers or the window closes.
    always_comb begin
        chk_next = chk_state;
        case (chk_state)
            C_IDLE:  if (chk_start) chk_next = C_WAIT;
            C_WAIT:  if (i_ChkEnable || wait_last) chk_next = C_IDLE;
            default: chk_next = C_IDLE;
        endcase
    end

    // Check stage outputs: classify the handed-off frame and select the byte to push.
    always_comb begin
        chk_start   = frame_ready & o_ChkData[10] & (o_ChkParity != 2'b00);
        push_direct = frame_ready & o_ChkData[10] & (o_ChkParity == 2'b00);
        o_FrameErr  = frame_ready & ~o_ChkData[10];
        o_ChkEnable = chk_start;
        push_chk    = (chk_state == C_WAIT) & i_ChkEnable;
        timeout     = (chk_state == C_WAIT) & ~i_ChkEnable & wait_last;
        push        = push_direct | push_chk;
        push_data   = push_chk ? i_ChkData : o_ChkData[8:1];
        o_Busy      = (rx_state != RX_IDLE) | frame_ready | (chk_state != C_IDLE);
    end

    // Checker response window counter and registered timeout pulse.
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wait_cnt    <= '0;
            o_ParityErr <= 1'b0;
        end else begin
            o_ParityErr <= timeout;
            if (chk_start)                 wait_cnt <= '0;
            else if (chk_state == C_WAIT)  wait_cnt <= wait_cnt + WW'(1);
        end
    end

    assign o_Valid     = (count != '0);
    assign full        = (count == FULL_CNT);
    assign pop         = o_Valid & i_Ready;
    assign accept      = push & (~full | pop);
    assign overrun_now = push & full & ~pop;

    // FIFO storage; contents need no reset because occupancy guards every read.
    always_ff @(posedge i_Pclk) begin
        if (accept) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, occupancy and show-ahead head register.
    always_ff @(posedge i_Pclk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_Data    <= '0;
            o_Overrun <= 1'b0;
        end else begin
            o_Overrun <= overrun_now;
            if (accept) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            case ({accept, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (pop) begin
                if (count > CW'(1)) o_Data <= mem[rd_ptr + PW'(1)];
                else if (accept)    o_Data <= push_data;
            end else if (accept && count == '0) begin
                o_Data <= push_data;
            end
        end
    end

endmodule

// File: tb/tb_usrt_rx_ctrl.sv
// tb_usrt_rx_ctrl: directed and randomized bench for usrt_rx_ctrl.
// A behavioural parity checker answers the DUT strobes; a queue model
// predicts FIFO contents and error pulse counts from the frame rules.

module tb_usrt_rx_ctrl;

    localparam int DEPTH    = 4;
    localparam int CHK_WAIT = 2;

    logic        clk = 1'b0;
    logic        rst_n, enable, rx, ready;
    logic [1:0]  parity;
    logic        chk_strobe, chk_ack;
    logic [1:0]  chk_mode;
    logic [10:0] chk_frame;
    logic [7:0]  chk_payload, data;
    logic        valid, frame_err, parity_err, overrun, busy;

    int checks = 0;
    int errors = 0;
    int n_ferr = 0, n_perr = 0, n_ovr = 0, n_chk = 0;
    int e_ferr = 0, e_perr = 0, e_ovr = 0, e_chk = 0;
    logic [7:0] exp_q[$];

    usrt_rx_ctrl #(.DEPTH(DEPTH), .CHK_WAIT(CHK_WAIT)) dut (
        .i_Pclk(clk), .i_Rst_n(rst_n), .i_Enable(enable), .i_Rx(rx), .i_Parity(parity),
        .o_ChkEnable(chk_strobe), .o_ChkParity(chk_mode), .o_ChkData(chk_frame),
        .i_ChkEnable(chk_ack), .i_ChkData(chk_payload),
        .o_Data(data), .o_Valid(valid), .i_Ready(ready),
        .o_FrameErr(frame_err), .o_ParityErr(parity_err), .o_Overrun(overrun), .o_Busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic parity_ok(input logic [7:0] d, input logic p, input logic [1:0] mode);
        int ones;
        ones = $countones({d, p});
        case (mode)
            2'b01:   return (ones % 2) == 0;
            2'b10:   return (ones % 2) == 1;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic p, input logic stop);
        return {stop, p, d, 1'b0};
    endfunction

    // Count every error and strobe pulse seen mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err)  n_ferr <= n_ferr + 1;
            if (parity_err) n_perr <= n_perr + 1;
            if (overrun)    n_ovr  <= n_ovr + 1;
            if (chk_strobe) n_chk  <= n_chk + 1;
        end
    end

    // Behavioural rxparity: one cycle after a strobe, acknowledge a correct frame with its byte.
    initial begin
        logic       ok;
        logic [7:0] pay;
        chk_ack     = 1'b0;
        chk_payload = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && chk_strobe) begin
                ok  = parity_ok(chk_frame[8:1], chk_frame[9], chk_mode);
                pay = chk_frame[8:1];
                @(posedge clk); #1;
                chk_ack     = ok;
                chk_payload = ok ? pay : 8'h00;
                @(posedge clk); #1;
                chk_ack     = 1'b0;
                chk_payload = 8'h00;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach its end");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Serialise one frame LSB first, one bit per clock; returns 1ns after edge t10.
    task automatic apply_stimulus(input logic [10:0] f, input logic [1:0] mode);
        parity = mode;
        enable = 1'b1;
        for (int k = 0; k < 11; k++) begin
            rx = f[k];
            step(1);
        end
        rx = 1'b1;
    endtask

    task automatic model_push(input logic [7:0] d);
        if (exp_q.size() == DEPTH) e_ovr++;
        else exp_q.push_back(d);
    endtask

    task automatic model_frame(input logic [10:0] f, input logic [1:0] mode);
        if (!f[10]) e_ferr++;
        else if (mode == 2'b00 || mode == 2'b11) model_push(f[8:1]);
        else begin
            e_chk++;
            if (parity_ok(f[8:1], f[9], mode)) model_push(f[8:1]);
            else e_perr++;
        end
    endtask

    task automatic check_counts(input string tag);
        check_output({tag, "_frame_err"}, n_ferr, e_ferr);
        check_output({tag, "_parity_err"}, n_perr, e_perr);
        check_output({tag, "_overrun"}, n_ovr, e_ovr);
        check_output({tag, "_chk_strobes"}, n_chk, e_chk);
    endtask

    // Hold ready high, compare each head against the model, then pop once more on empty.
    task automatic drain_fifo(input string tag);
        ready = 1'b1;
        while (exp_q.size() > 0) begin
            check_output({tag, "_valid"}, valid, 1);
            check_output({tag, "_data"}, data, exp_q[0]);
            step(1);
            void'(exp_q.pop_front());
        end
        step(1);
        ready = 1'b0;
        check_output({tag, "_empty"}, valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_data"}, data, 0);
        check_output({tag, "_valid"}, valid, 0);
        check_output({tag, "_busy"}, busy, 0);
        check_output({tag, "_chk_en"}, chk_strobe, 0);
        check_output({tag, "_chk_data"}, chk_frame, 0);
        check_output({tag, "_chk_mode"}, chk_mode, 0);
        check_output({tag, "_flags"}, {frame_err, parity_err, overrun}, 0);
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  d;
        logic [1:0]  m;
        logic        p;

        rst_n  = 1'b0;
        enable = 1'b0;
        rx     = 1'b1;
        parity = 2'b00;
        ready  = 1'b0;
        step(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        step(1);

        $display("[TB] even mode, good parity");
        f = 11'b10001101010;
        model_frame(f, 2'b01);
        apply_stimulus(f, 2'b01);
        check_output("even_t11_chk_en", chk_strobe, 1);
        check_output("even_t11_chk_data", chk_frame, 11'b10001101010);
        check_output("even_t11_chk_mode", chk_mode, 2'b01);
        check_output("even_t11_frame_err", frame_err, 0);
        check_output("even_t11_valid", valid, 0);
        step(1);
        check_output("even_t12_chk_en", chk_strobe, 0);
        check_output("even_t12_valid", valid, 0);
        step(1);
        check_output("even_after_t12_valid", valid, 1);
        check_output("even_after_t12_data", data, 8'h35);
        step(3);
        check_counts("even_good");
        drain_fifo("even_good");

        $display("[TB] even mode, bad parity");
        f = 11'b11001101010;
        model_frame(f, 2'b01);
        apply_stimulus(f, 2'b01);
        check_output("even_bad_chk_en", chk_strobe, 1);
        step(2);
        check_output("even_bad_t13_perr", parity_err, 0);
        step(1);
        check_output("even_bad_t14_perr", parity_err, 1);
        step(1);
        check_output("even_bad_t15_perr", parity_err, 0);
        check_output("even_bad_valid", valid, 0);
        check_counts("even_bad");

        $display("[TB] odd mode, good then bad parity");
        f = 11'b10001101000;
        model_frame(f, 2'b10);
        apply_stimulus(f, 2'b10);
        step(3);
        check_output("odd_good_data", data, 8'h34);
        check_counts("odd_good");
        drain_fifo("odd_good");
        f = 11'b11001101000;
        model_frame(f, 2'b10);
        apply_stimulus(f, 2'b10);
        step(5);
        check_output("odd_bad_valid", valid, 0);
        check_counts("odd_bad");

        $display("[TB] bad stop bit, then aborted frame");
        f = 11'b00001101010;
        model_frame(f, 2'b01);
        apply_stimulus(f, 2'b01);
        check_output("stop_t11_frame_err", frame_err, 1);
        check_output("stop_t11_chk_en", chk_strobe, 0);
        step(1);
        check_output("stop_t12_frame_err", frame_err, 0);
        f = make_frame(8'hA5, 1'b0, 1'b1);
        enable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            rx = f[k];
            step(1);
        end
        check_output("abort_busy_before", busy, 1);
        enable = 1'b0;
        rx     = 1'b1;
        step(1);
        check_output("abort_busy_after", busy, 0);
        step(12);
        check_output("abort_valid", valid, 0);
        check_counts("abort");

        $display("[TB] five back-to-back frames into a four-entry FIFO");
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            f = make_frame(d, ^d, 1'b1);
            model_frame(f, 2'b01);
            apply_stimulus(f, 2'b01);
        end
        step(5);
        check_counts("overrun");
        drain_fifo("overrun");

        $display("[TB] push and pop together on a full FIFO");
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            f = make_frame(d, 1'($urandom), 1'b1);
            model_frame(f, 2'b00);
            apply_stimulus(f, 2'b00);
        end
        d = 8'($urandom);
        f = make_frame(d, 1'b0, 1'b1);
        apply_stimulus(f, 2'b00);
        ready = 1'b1;
        step(1);
        ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(d);
        step(3);
        check_counts("full_push_pop");
        drain_fifo("full_push_pop");

        $display("[TB] randomized frame batches");
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 6; i++) begin
                d = 8'($urandom);
                m = 2'($urandom_range(0, 3));
                if (m == 2'b01)      p = ^d;
                else if (m == 2'b10) p = ~^d;
                else                 p = 1'($urandom);
                if ($urandom_range(0, 3) == 0) p = ~p;
                f = make_frame(d, p, ($urandom_range(0, 7) != 0));
                model_frame(f, m);
                apply_stimulus(f, m);
                step($urandom_range(0, 2));
            end
            step(6);
            check_counts("random");
            drain_fifo("random");
        end

        $display("[TB] asynchronous reset mid-frame");
        for (int i = 0; i < 2; i++) begin
            d = 8'($urandom);
            f = make_frame(d, 1'b1, 1'b1);
            model_frame(f, 2'b00);
            apply_stimulus(f, 2'b00);
        end
        step(2);
        check_output("pre_reset_valid", valid, 1);
        f = make_frame(8'h5A, 1'b0, 1'b1);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) begin
            rx = f[k];
            step(1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        rx = 1'b1;
        step(1);
        rst_n = 1'b1;
        step(1);
        f = make_frame(8'hC3, ^8'hC3, 1'b1);
        model_frame(f, 2'b01);
        apply_stimulus(f, 2'b01);
        step(3);
        check_output("post_reset_data", data, 8'hC3);
        check_counts("post_reset");
        drain_fifo("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usrt_rx_ctrl.md
# usrt_rx_ctrl

USRT receive-side controller. It samples the serial line on the USRT bit clock and assembles 11-bit frames. It sequences the `rxparity` checker with one strobe per frame and buffers accepted bytes in a small show-ahead FIFO behind a valid/ready handshake. It sits between the RX pin and the host/bus interface and reports frame, parity and overrun errors.

## Interface
- `DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `CHK_WAIT`, 2: cycles to wait for checker response after strobe.
- `i_Pclk`  in  1  USRT bit clock; all logic on rising edge.
- `i_Rst_n`  in  1  reset: asynchronous, active-low.
- `i_Enable`  in  1  receiver enable.
- `i_Rx`  in  1  serial line, one bit per `i_Pclk`, idle high.
- `i_Parity`  in  2  mode: 00 none, 01 even, 10 odd, 11 treated as 00.
- `o_ChkEnable`  out  1  one-cycle strobe to checker.
- `o_ChkParity`  out  2  mode latched for this frame.
- `o_ChkData`  out  11  captured frame to checker.
- `i_ChkEnable`  in  1  checker accept pulse (parity correct).
- `i_ChkData`  in  8  checker payload, valid with `i_ChkEnable`.
- `o_Data`  out  8  FIFO head byte.
- `o_Valid`  out  1  FIFO non-empty.
- `i_Ready`  in  1  consumer pop; pop when `o_Valid & i_Ready`.
- `o_FrameErr`  out  1  one-cycle pulse, bad stop bit.
- `o_ParityErr`  out  1  one-cycle pulse, checker timeout.
- `o_Overrun`  out  1  one-cycle pulse, byte dropped on full FIFO.
- `o_Busy`  out  1  receive FSM not IDLE or check pending.

## Operation
- Frame (line order, LSB first): bit0 start=0, bits8:1 data LSB first, bit9 parity, bit10 stop=1. In mode 00, bit9 is still present on the line and is ignored.
- Receive FSM, states IDLE and SHIFT:
  - IDLE: `i_Enable & ~i_Rx` → store bit0, latch `i_Parity`, count=1, go to SHIFT.
  - SHIFT: store `i_Rx` at index count, count++. After bit10 is stored, go to IDLE and hand the frame to the check stage.
  - `i_Enable` low in SHIFT: abort the frame, go to IDLE, no flags raised.
- Check stage, states C_IDLE and C_WAIT, independent of the receive FSM:
  - On handoff with stop=0: pulse `o_FrameErr`, discard the frame.
  - On handoff with mode 00/11: push frame[8:1] directly.
  - On handoff otherwise: pulse `o_ChkEnable` with `o_ChkData`/`o_ChkParity`, enter C_WAIT.
  - C_WAIT, `i_ChkEnable` sampled: push `i_ChkData`, go to C_IDLE.
  - C_WAIT, no `i_ChkEnable` after `CHK_WAIT` cycles: pulse `o_ParityErr`, discard, go to C_IDLE.
- A new start bit is accepted in the cycle the receive FSM returns to IDLE, so frames can be back-to-back. The check stage always finishes within 11 cycles, so a check never overlaps the next handoff.
- FIFO:
  - Push when full with no pop in the same cycle: drop the new byte, pulse `o_Overrun`. Existing entries are unchanged.
  - Push and pop in the same cycle when full: both happen, no overrun.
  - Pop when empty: ignored.
  - Read and write pointers wrap modulo `DEPTH`. Occupancy counter is log2(`DEPTH`)+1 bits.
- Reset value of every output is 0: `o_Data`=0x00, `o_ChkData`=0, `o_ChkParity`=00, all strobes, flags, `o_Valid` and `o_Busy` low. FIFO is emptied and both FSMs return to IDLE/C_IDLE. Reset asserted mid-frame discards the partial frame and any pending check.

## Timing
- Start bit sampled at edge t0; bit k sampled at edge tk; frame complete at t10.
- Cycle after t10 (edge t11 visible):
  - parity mode: `o_ChkEnable` high for exactly one cycle;
  - bad stop bit: `o_FrameErr` high;
  - mode 00: byte pushed, `o_Valid` high after t11.
- Checker has one cycle of latency: `i_ChkEnable` is sampled at t12, and `o_Valid` is high after t12.
- Timeout: if `i_ChkEnable` is not seen at t12..t(11+`CHK_WAIT`), `o_ParityErr` is high in the following cycle.
- `o_Data` changes only on push-into-empty or pop. Pop takes effect at the clock edge where `o_Valid & i_Ready`.

## Test plan
- Even mode (01), serialize 11'b10001101010, rxparity attached → `o_ChkEnable` one cycle at t11, `o_Data`=0x35 with `o_Valid` after t12, no flags.
- Even mode, 11'b11001101010 (bad parity) → `o_ParityErr` pulse at t14 (`CHK_WAIT`=2), FIFO stays empty.
- Odd mode (10), 11'b10001101000 → `o_Data`=0x34. Repeat with 11'b11001101000 → `o_ParityErr`, nothing pushed.
- Stop bit 0 (11'b00001101010) → `o_FrameErr` at t11, no `o_ChkEnable`. Drop `i_Enable` at t5 of the next frame → abort, no flags, `o_Busy` low after one cycle.
- Five back-to-back good frames 0x01..0x05 with `i_Ready`=0, `DEPTH`=4 → 0x01..0x04 buffered, `o_Overrun` on the fifth. Then hold `i_Ready`=1 → 0x01..0x04 are popped in order and `o_Valid` falls.
- Assert `i_Rst_n`=0 asynchronously mid-SHIFT with 2 bytes in the FIFO → all outputs go to 0 immediately. After release, the next valid frame is received correctly.
